// File: rtl/simd_regime_encoder_pkg.sv
// rtl/simd_regime_encoder_pkg.sv - mode encodings and lane geometry for the SIMD regime encoder
package posit_simd_pkg;

  typedef enum logic [1:0] {
    MODE_8   = 2'b00,
    MODE_16  = 2'b01,
    MODE_32  = 2'b10,
    MODE_ILL = 2'b11
  } mode_e;

  localparam int LANE_W_8  = 8;
  localparam int LANE_W_16 = 16;
  localparam int LANE_W_32 = 32;

  localparam int CNT_W_8  = 3;
  localparam int CNT_W_16 = 4;
  localparam int CNT_W_32 = 5;

  localparam int CNT_OFF_16_LO = 0;
  localparam int CNT_OFF_16_HI = 4;
  localparam int CNT_OFF_32    = 0;

  localparam int EN_BIT_16_LO = 0;
  localparam int EN_BIT_16_HI = 2;
  localparam int EN_BIT_32    = 0;

  // Lane slots that carry a pattern in each mode; slot index equals lane_en bit.
  function automatic logic [3:0] slot_mask(mode_e m);
    logic [3:0] v;
    v = '0;
    case (m)
      MODE_8:  v = 4'hF;
      MODE_16: begin
        v[EN_BIT_16_LO] = 1'b1;
        v[EN_BIT_16_HI] = 1'b1;
      end
      MODE_32: v[EN_BIT_32] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/simd_regime_encoder_if.sv
// rtl/simd_regime_encoder_if.sv - request/result handshake bundle of the SIMD regime encoder
interface simd_regime_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [11:0] count;
  logic [3:0]  polarity;
  logic [3:0]  lane_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_lane_valid;
  logic [3:0]  out_err;

  modport master (
    output in_valid, mode, count, polarity, lane_en, out_ready,
    input  in_ready, out_valid, out_data, out_lane_valid, out_err
  );

  modport slave (
    input  in_valid, mode, count, polarity, lane_en, out_ready,
    output in_ready, out_valid, out_data, out_lane_valid, out_err
  );
endinterface

// File: rtl/simd_regime_encoder_regime_lane_gen.sv
// rtl/simd_regime_encoder_regime_lane_gen.sv - one lane of regime pattern, right-aligned in 32 bits
module regime_lane_gen #(
  parameter bit TERM_EN = 1'b1
) (
  input  logic [5:0]  i_width,
  input  logic [4:0]  i_k,
  input  logic        i_r,
  output logic [31:0] o_pattern
);

  logic [31:0] w_run_ones;
  logic [31:0] w_run;
  logic [31:0] w_term;
  logic [5:0]  w_shift;

  // Caller guarantees 1 <= k <= width-1, so the shift never wraps.
  always_comb begin
    w_run_ones = (32'd1 << i_k) - 32'd1;
    w_shift    = i_width - 6'd1 - {1'b0, i_k};
    w_run      = w_run_ones << w_shift;
    w_term     = '0;
    if (TERM_EN && ({1'b0, i_k} < (i_width - 6'd1))) begin
      w_term = 32'd1 << (w_shift - 6'd1);
    end
    // A one-run ends in a zero terminator, so only the zero-run needs the extra bit.
    o_pattern = i_r ? w_run : w_term;
  end

endmodule

// File: rtl/simd_regime_encoder.sv
// rtl/simd_regime_encoder.sv - two-stage SIMD posit regime generator (4x8 / 2x16 / 1x32)
module simd_regime_encoder
  import posit_simd_pkg::*;
#(
  parameter bit TERM_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  simd_regime_encoder_if.slave bus
);

  logic        r_s1_valid;
  mode_e       r_mode;
  logic [11:0] r_count;
  logic [3:0]  r_pol;
  logic [3:0]  r_lane_en;

  logic        r_s2_valid;
  logic [31:0] r_data;
  logic [3:0]  r_lv;
  logic [3:0]  r_err;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic [4:0]  w_k [4];
  logic [5:0]  w_w [4];
  logic [31:0] w_pat [4];
  logic [31:0] w_pat_m [4];
  logic [3:0]  w_en;
  logic [31:0] w_data;
  logic [3:0]  w_lv;
  logic [3:0]  w_err;

  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = w_s2_adv || !r_s1_valid;
  assign bus.in_ready = w_s1_adv;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_k[i] = 5'(r_count[CNT_W_8*i +: CNT_W_8]);
      w_w[i] = 6'(LANE_W_8);
    end
    case (r_mode)
      MODE_16: begin
        w_k[0] = 5'(r_count[CNT_OFF_16_LO +: CNT_W_16]);
        w_w[0] = 6'(LANE_W_16);
        w_k[2] = 5'(r_count[CNT_OFF_16_HI +: CNT_W_16]);
        w_w[2] = 6'(LANE_W_16);
      end
      MODE_32: begin
        w_k[0] = r_count[CNT_OFF_32 +: CNT_W_32];
        w_w[0] = 6'(LANE_W_32);
      end
      default: ;
    endcase
    w_en = r_lane_en & slot_mask(r_mode);
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    regime_lane_gen #(.TERM_EN(TERM_EN)) u_lane (
      .i_width   (w_w[g]),
      .i_k       (w_k[g]),
      .i_r       (r_pol[g]),
      .o_pattern (w_pat[g])
    );
  end

  always_comb begin
    w_data = '0;
    w_lv   = '0;
    w_err  = '0;
    for (int i = 0; i < 4; i++) begin
      w_lv[i]    = w_en[i] && (w_k[i] != 5'd0);
      w_err[i]   = w_en[i] && (w_k[i] == 5'd0);
      w_pat_m[i] = w_lv[i] ? w_pat[i] : '0;
    end
    // Inactive slots are already zero, so packing is a plain OR of shifted lanes.
    case (r_mode)
      MODE_8: begin
        for (int i = 0; i < 4; i++) begin
          w_data = w_data | ((w_pat_m[i] & 32'h0000_00FF) << (LANE_W_8 * i));
        end
      end
      MODE_16: w_data = w_pat_m[0] | (w_pat_m[2] << LANE_W_16);
      MODE_32: w_data = w_pat_m[0];
      default: begin
        w_lv  = '0;
        w_err = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_mode     <= MODE_8;
      r_count    <= '0;
      r_pol      <= '0;
      r_lane_en  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      r_mode     <= mode_e'(bus.mode);
      r_count    <= bus.count;
      r_pol      <= bus.polarity;
      r_lane_en  <= bus.lane_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_lv       <= '0;
      r_err      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_data     <= w_data;
      r_lv       <= w_lv;
      r_err      <= w_err;
    end
  end

  assign bus.out_valid      = r_s2_valid;
  assign bus.out_data       = r_data;
  assign bus.out_lane_valid = r_lv;
  assign bus.out_err        = r_err;

endmodule

// File: doc/simd_regime_encoder.md
Name: simd_regime_encoder

Overview:
- SIMD posit regime-field generator; the inverse of the clocked SIMD leading-bit detector.
- Takes a packed run-length count, a regime polarity and a lane-enable per lane. Produces the left-aligned regime bit pattern for each lane.
- Supports the same three precision modes: 4x8, 2x16 and 1x32. Feeds the posit pack/round stage on the encode path.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- TERM_EN, 1: when 1, append the terminating ~polarity bit after the run if it fits in the lane; when 0, never emit it.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- mode  input  2  00 = 4x8, 01 = 2x16, 10 = 1x32, 11 = illegal
- count  input  12  packed run lengths, same packing as the detector output
- polarity  input  4  regime bit value per lane, same bit positions as lane_en
- lane_en  input  4  per-lane valid, same bit positions as the detector valid output
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  32  packed regime patterns
- out_lane_valid  output  4  lane produced a pattern
- out_err  output  4  per-lane error flag

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Lane mapping, mode 00:
  - lane i uses count[3i+2:3i], lane_en[i], polarity[i]
  - lane i drives out_data[8i+7:8i]
  - legal k = 1..7
- Lane mapping, mode 01:
  - low word: count[3:0], bit index 0, out_data[15:0]
  - high word: count[7:4], bit index 2, out_data[31:16]
  - legal k = 1..15
- Lane mapping, mode 10:
  - count[4:0], bit index 0, out_data[31:0]
  - legal k = 1..31
- Unused count, lane_en and polarity bits are ignored. Unused out_lane_valid and out_err bits are 0.
- Pattern for a lane of width W with run length k and polarity r:
  - bit W-1 = 0 (sign slot)
  - bits W-2 down to W-1-k = r
  - if TERM_EN and k < W-1: bit W-2-k = ~r
  - all remaining bits 0
  - k = W-1 saturates: no terminator.
- Error and disabled lanes:
  - enabled lane with k = 0: out_err set, pattern 0, out_lane_valid 0
  - disabled lane: pattern 0, flags 0
- mode 11: out_err = 4'hF for the transaction, out_data = 0, out_lane_valid = 0.
- Pipeline:
  - S1 registers the request.
  - S2 holds the computed result and drives the outputs.
  - Latency: 2 cycles from accept (in_valid & in_ready) to out_valid with no stall.
  - Throughput: 1 transaction per cycle.
- Handshake rules:
  - S2 advances when !out_valid | out_ready.
  - S1 advances when S2 advances or S1 is empty.
  - in_ready = !s1_valid | s1_advance.
  - Outputs hold stable while out_valid & !out_ready.
  - in_ready is combinational from out_ready; no combinational path from in_* to out_*.
  - mode travels with each transaction, so consecutive transactions may use different modes.
- Reset:
  - out_valid, out_data, out_lane_valid, out_err and internal valid flags go to 0.
  - in_ready is 1 after reset.
  - Reset mid-operation drops in-flight transactions; nothing is emitted for them after reset releases.

Decomposition:
- Package posit_simd_pkg holds:
  - mode encodings MODE_8, MODE_16, MODE_32, MODE_ILL
  - per-mode lane widths, count field offsets and widths
  - lane_en bit positions
- Sub-module regime_lane_gen (combinational): from W-select, k and r, build the 32-bit-capable pattern by mask-and-shift. Instantiate once per lane slot (4 instances); the top selects and packs per mode.

Test Plan:
- mode 00, count 12'h912, lane_en F, polarity 0 -> out_data 32'h04041010, lane_valid F, err 0, two cycles after accept.
- Same as above with polarity 4'b1010 -> out_data 32'h78046010.
- mode 01, count 12'h0BB, lane_en 5:
  - polarity 0 -> out_data 32'h00080008, lane_valid 5
  - polarity 4'b0100 -> out_data 32'h7FF00008
- mode 10:
  - count 12'h01E, pol 0 -> out_data 32'h00000001
  - count 12'h01F, pol 1 -> out_data 32'h7FFFFFFF (no terminator)
- Errors:
  - mode 00, lane 0 count 0, lane_en F -> out_err 4'b0001, out_data[7:0] = 0
  - mode 11 -> out_err F, out_data 0
- Backpressure and reset:
  - Issue 3 back-to-back requests with out_ready low -> in_ready drops after 2 accepts, out_data stable, all 3 delivered in order when out_ready rises.
  - Assert rst_n low mid-stream -> out_valid 0 immediately, no stale outputs.
